// File: rtl/fb_pixel_store.sv
// 1-bit-per-pixel frame buffer: display read port plus a read-modify-write / clear
// engine on the second port of a dual-port word memory.
module fb_pixel_store #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned WORD_W = 16
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic [9:0] pixel_x,
  input  logic [8:0] pixel_y,
  output logic       pixel,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic       wr_data,
  input  logic       clr_req,
  output logic       busy,
  output logic       clr_done,
  output logic       wr_err
);

  localparam int unsigned X_W            = 10;
  localparam int unsigned Y_W            = 9;
  localparam int unsigned ADDR_W         = 15;
  localparam int unsigned BIT_W          = $clog2(WORD_W);
  localparam int unsigned WORDS_PER_LINE = H_RES / WORD_W;
  localparam int unsigned WORD_CNT       = (H_RES * V_RES) / WORD_W;

  typedef enum logic [1:0] {IDLE, RD, WR, CLEAR} state_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(x[X_W-1:BIT_W]);
  endfunction

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < H_RES) && (32'(y) < V_RES);
  endfunction

  logic [WORD_W-1:0] mem [WORD_CNT];

  // Display port: coordinates registered on one edge, bit presented on the next
  logic [ADDR_W-1:0] rd_addr_q;
  logic [BIT_W-1:0]  rd_bit_q;
  logic              rd_ok_q;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      rd_addr_q <= '0;
      rd_bit_q  <= '0;
      rd_ok_q   <= 1'b0;
      pixel     <= 1'b0;
    end else begin
      rd_addr_q <= word_addr(pixel_x, pixel_y);
      rd_bit_q  <= pixel_x[BIT_W-1:0];
      rd_ok_q   <= in_range(pixel_x, pixel_y);
      pixel     <= rd_ok_q ? mem[rd_addr_q][rd_bit_q] : 1'b0;
    end
  end

  state_t            state;
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] b_addr_q;
  logic [BIT_W-1:0]  b_bit_q;
  logic              b_data_q;
  logic              b_ok_q;
  logic [WORD_W-1:0] b_word_q;

  // Update engine: single-pixel RMW and full-screen clear share port B
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state    <= CLEAR;
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
      b_addr_q <= '0;
      b_bit_q  <= '0;
      b_data_q <= 1'b0;
      b_ok_q   <= 1'b0;
      b_word_q <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req || clr_pend) begin
            state    <= CLEAR;
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end else if (wr_valid && wr_ready) begin
            state    <= RD;
            wr_ready <= 1'b0;
            b_addr_q <= word_addr(wr_x, wr_y);
            b_bit_q  <= wr_x[BIT_W-1:0];
            b_data_q <= wr_data;
            b_ok_q   <= in_range(wr_x, wr_y);
            if (!in_range(wr_x, wr_y)) wr_err <= 1'b1;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        RD: begin
          state <= WR;
          if (b_ok_q) b_word_q <= mem[b_addr_q];
          if (clr_req) clr_pend <= 1'b1;
        end
        WR: begin
          // A clear requested during the RMW starts straight after the write-back
          if (clr_req || clr_pend) begin
            state    <= CLEAR;
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            wr_ready <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == ADDR_W'(WORD_CNT - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            wr_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WORD_W-1:0] mem_wdata_c;

  // Port B write selection: zero word while clearing, merged word on write-back
  always_comb begin
    mem_we_c             = 1'b0;
    mem_waddr_c          = b_addr_q;
    mem_wdata_c          = b_word_q;
    mem_wdata_c[b_bit_q] = b_data_q;
    if (state == CLEAR) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_cnt;
      mem_wdata_c = '0;
    end else if (state == WR && b_ok_q) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

endmodule

// File: tb/tb_fb_pixel_store.sv
// Self-checking bench for fb_pixel_store against a per-pixel reference bitmap.
module tb_fb_pixel_store;

  localparam int H   = 640;
  localparam int V   = 480;
  localparam int WDS = 19200;

  logic       CLOCK_50 = 1'b0;
  logic       nReset   = 1'b0;
  logic [9:0] pixel_x  = '0;
  logic [8:0] pixel_y  = '0;
  logic       pixel;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [9:0] wr_x     = '0;
  logic [8:0] wr_y     = '0;
  logic       wr_data  = 1'b0;
  logic       clr_req  = 1'b0;
  logic       busy;
  logic       clr_done;
  logic       wr_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  bit          fb [H*V];

  fb_pixel_store #(.H_RES(640), .V_RES(480), .WORD_W(16)) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel(pixel),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_err(wr_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic model_clear();
    foreach (fb[i]) fb[i] = 1'b0;
  endtask

  task automatic model_write(input int x, input int y, input bit d);
    if (x < H && y < V) fb[y*H + x] = d;
  endtask

  function automatic bit model_px(input int x, input int y);
    return fb[y*H + x];
  endfunction

  // Display read: drive coords, value appears after the second following edge
  task automatic rd_pix(input int x, input int y, output logic v);
    @(negedge CLOCK_50);
    pixel_x = 10'(x);
    pixel_y = 9'(y);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    v = pixel;
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic do_write(input int x, input int y, input bit d, output bit ok);
    ok       = 1'b0;
    wr_x     = 10'(x);
    wr_y     = 9'(y);
    wr_data  = d;
    wr_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (wr_ready) begin
        @(posedge CLOCK_50);
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
  endtask

  // Called at a negedge; counts busy cycles until busy drops
  task automatic wait_clear(output int busy_cyc, output int dones, output logic rdy);
    busy_cyc = 0;
    dones    = 0;
    rdy      = 1'b0;
    for (int k = 0; k < 25000; k++) begin
      if (clr_done) dones++;
      if (!busy) begin
        rdy = wr_ready;
        return;
      end
      busy_cyc++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_reset();
    int   bc, dn;
    logic rdy, v;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks += 5;
    if (pixel !== 1'b0)    begin n_fail++; $display("FAIL reset_pixel: got %b want 0", pixel); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done: got %b want 0", clr_done); end
    if (wr_err !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    nReset = 1'b1;
    wait_clear(bc, dn, rdy);
    model_clear();
    n_checks += 3;
    if (bc != WDS)     begin n_fail++; $display("FAIL autoclear_busy_cycles: got %0d want %0d", bc, WDS); end
    if (dn != 1)       begin n_fail++; $display("FAIL autoclear_done_count: got %0d want 1", dn); end
    if (rdy !== 1'b1)  begin n_fail++; $display("FAIL autoclear_ready: got %b want 1", rdy); end
    @(negedge CLOCK_50);
    n_checks++;
    if (clr_done !== 1'b0) begin n_fail++; $display("FAIL autoclear_done_pulse: got %b want 0", clr_done); end
    for (int i = 0; i < 8; i++) begin
      int x, y;
      x = int'($urandom_range(0, H-1));
      y = int'($urandom_range(0, V-1));
      rd_pix(x, y, v);
      n_checks++;
      if (v !== model_px(x, y)) begin n_fail++; $display("FAIL autoclear_read(%0d,%0d): got %b want %b", x, y, v, model_px(x, y)); end
    end
  endtask

  task automatic test_single_write();
    logic r0, r1, r2, v;
    @(negedge CLOCK_50);
    pixel_x = 10'd4;
    pixel_y = 9'd3;
    wr_x = 10'd5; wr_y = 9'd3; wr_data = 1'b1; wr_valid = 1'b1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b want 1", wr_ready); end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); wr_valid = 1'b0; r0 = wr_ready;
    @(negedge CLOCK_50); r1 = wr_ready;
    @(negedge CLOCK_50); r2 = wr_ready;
    model_write(5, 3, 1'b1);
    n_checks++;
    if ({r0, r1, r2} !== 3'b001) begin n_fail++; $display("FAIL single_ready_window: got %b%b%b want 001", r0, r1, r2); end
    pixel_x = 10'd5;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks++;
    if (pixel !== model_px(4, 3)) begin n_fail++; $display("FAIL read_latency_early: got %b want %b", pixel, model_px(4, 3)); end
    @(negedge CLOCK_50);
    n_checks++;
    if (pixel !== model_px(5, 3)) begin n_fail++; $display("FAIL read_latency_5_3: got %b want %b", pixel, model_px(5, 3)); end
    rd_pix(6, 3, v);
    n_checks++;
    if (v !== model_px(6, 3)) begin n_fail++; $display("FAIL single_neighbour_6_3: got %b want %b", v, model_px(6, 3)); end
    rd_pix(4, 3, v);
    n_checks++;
    if (v !== model_px(4, 3)) begin n_fail++; $display("FAIL single_neighbour_4_3: got %b want %b", v, model_px(4, 3)); end
  endtask

  task automatic test_collision();
    @(negedge CLOCK_50);
    pixel_x = 10'd7;
    pixel_y = 9'd10;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_x = 10'd7; wr_y = 9'd10; wr_data = 1'b1; wr_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); wr_valid = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks++;
    if (pixel !== model_px(7, 10)) begin n_fail++; $display("FAIL collision_prewrite: got %b want %b", pixel, model_px(7, 10)); end
    model_write(7, 10, 1'b1);
    @(negedge CLOCK_50);
    n_checks++;
    if (pixel !== model_px(7, 10)) begin n_fail++; $display("FAIL collision_postwrite: got %b want %b", pixel, model_px(7, 10)); end
  endtask

  task automatic test_word_rmw();
    bit   ok;
    logic v;
    @(negedge CLOCK_50);
    for (int x = 16; x < 32; x++) begin
      do_write(x, 479, 1'b1, ok);
      model_write(x, 479, 1'b1);
    end
    do_write(20, 479, 1'b0, ok);
    model_write(20, 479, 1'b0);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rmw_handshake: got %b want 1", ok); end
    for (int x = 15; x <= 32; x++) begin
      rd_pix(x, 479, v);
      n_checks++;
      if (v !== model_px(x, 479)) begin n_fail++; $display("FAIL rmw_read(%0d,479): got %b want %b", x, v, model_px(x, 479)); end
    end
  endtask

  task automatic test_oob();
    bit   ok;
    logic v;
    @(negedge CLOCK_50);
    n_checks++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL oob_err_before: got %b want 0", wr_err); end
    do_write(640, 0, 1'b1, ok);
    n_checks += 2;
    if (ok !== 1'b1)     begin n_fail++; $display("FAIL oob_handshake: got %b want 1", ok); end
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL oob_err_set: got %b want 1", wr_err); end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready_back: got %b want 1", wr_ready); end
    do_write(100, 480, 1'b1, ok);
    rd_pix(0, 0, v);
    n_checks++;
    if (v !== model_px(0, 0)) begin n_fail++; $display("FAIL oob_read_0_0: got %b want %b", v, model_px(0, 0)); end
    rd_pix(0, 1, v);
    n_checks++;
    if (v !== model_px(0, 1)) begin n_fail++; $display("FAIL oob_read_0_1: got %b want %b", v, model_px(0, 1)); end
    n_checks++;
    if (wr_err !== 1'b1) begin n_fail++; $display("FAIL oob_err_sticky: got %b want 1", wr_err); end
  endtask

  task automatic test_back_to_back();
    int          qx[$], qy[$];
    int unsigned c0, n;
    bit          ok;
    logic        v;
    n = 30;
    @(negedge CLOCK_50);
    c0 = cyc;
    for (int i = 0; i < int'(n); i++) begin
      int x, y;
      bit d;
      x = int'($urandom_range(0, H-1));
      y = int'($urandom_range(0, V-1));
      d = 1'($urandom);
      if ($urandom_range(0, 7) == 0) x = H + int'($urandom_range(0, 383));
      do_write(x, y, d, ok);
      model_write(x, y, d);
      if (x < H) begin qx.push_back(x); qy.push_back(y); end
    end
    n_checks++;
    if (cyc - c0 != 3*n - 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d want %0d", cyc - c0, 3*n - 2); end
    foreach (qx[i]) begin
      rd_pix(qx[i], qy[i], v);
      n_checks++;
      if (v !== model_px(qx[i], qy[i])) begin n_fail++; $display("FAIL b2b_read(%0d,%0d): got %b want %b", qx[i], qy[i], v, model_px(qx[i], qy[i])); end
    end
  endtask

  task automatic test_clear_collision();
    int   bc, dn;
    logic rdy, v;
    bit   pre;
    pre = model_px(16, 479);
    @(negedge CLOCK_50);
    clr_req = 1'b1;
    wr_x = 10'd9; wr_y = 9'd9; wr_data = 1'b1; wr_valid = 1'b1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clrcol_ready_idle: got %b want 1", wr_ready); end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    clr_req = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL clrcol_busy: got %b want 1", busy); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clrcol_write_held: got %b want 0", wr_ready); end
    rd_pix(16, 479, v);
    n_checks++;
    if (v !== pre) begin n_fail++; $display("FAIL clear_display_read: got %b want %b", v, pre); end
    repeat (40) @(negedge CLOCK_50);
    clr_req = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    clr_req = 1'b0;
    wait_clear(bc, dn, rdy);
    model_clear();
    n_checks += 3;
    if (bc != WDS)    begin n_fail++; $display("FAIL restart_busy_cycles: got %0d want %0d", bc, WDS); end
    if (dn != 1)      begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", dn); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL clrcol_ready_at_done: got %b want 1", rdy); end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    model_write(9, 9, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clrcol_write_accepted: got %b want 0", wr_ready); end
    rd_pix(9, 9, v);
    n_checks++;
    if (v !== model_px(9, 9)) begin n_fail++; $display("FAIL clrcol_read_9_9: got %b want %b", v, model_px(9, 9)); end
    rd_pix(16, 479, v);
    n_checks++;
    if (v !== model_px(16, 479)) begin n_fail++; $display("FAIL clrcol_read_16_479: got %b want %b", v, model_px(16, 479)); end
  endtask

  task automatic test_clear_during_rmw();
    int   bc, dn;
    logic rdy, v;
    @(negedge CLOCK_50);
    wr_x = 10'd17; wr_y = 9'd479; wr_data = 1'b1; wr_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    clr_req  = 1'b1;
    model_write(17, 479, 1'b1);
    @(negedge CLOCK_50);
    clr_req = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmwclr_busy_in_wr: got %b want 0", busy); end
    @(negedge CLOCK_50);
    n_checks += 2;
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL rmwclr_busy_from_wr: got %b want 1", busy); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmwclr_no_idle: got %b want 0", wr_ready); end
    rd_pix(17, 479, v);
    n_checks++;
    if (v !== model_px(17, 479)) begin n_fail++; $display("FAIL rmwclr_write_done: got %b want %b", v, model_px(17, 479)); end
    wait_clear(bc, dn, rdy);
    model_clear();
    n_checks += 2;
    if (dn != 1)      begin n_fail++; $display("FAIL rmwclr_done_count: got %0d want 1", dn); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL rmwclr_ready: got %b want 1", rdy); end
  endtask

  task automatic test_reset_mid_write();
    int   bc, dn;
    logic rdy, v;
    bit   ok;
    @(negedge CLOCK_50);
    do_write(9, 9, 1'b1, ok);
    model_write(9, 9, 1'b1);
    rd_pix(9, 9, v);
    n_checks++;
    if (v !== model_px(9, 9)) begin n_fail++; $display("FAIL rst_pre_read: got %b want %b", v, model_px(9, 9)); end
    do_write(640, 5, 1'b0, ok);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_x = 10'd3; wr_y = 9'd3; wr_data = 1'b1; wr_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    @(negedge CLOCK_50);
    #3 nReset = 1'b0;
    #1;
    n_checks += 5;
    if (pixel !== 1'b0)    begin n_fail++; $display("FAIL rst_async_pixel: got %b want 0", pixel); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_ready: got %b want 0", wr_ready); end
    if (clr_done !== 1'b0) begin n_fail++; $display("FAIL rst_async_done: got %b want 0", clr_done); end
    if (wr_err !== 1'b0)   begin n_fail++; $display("FAIL rst_async_err: got %b want 0", wr_err); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL rst_async_busy: got %b want 1", busy); end
    repeat (3) @(negedge CLOCK_50);
    nReset = 1'b1;
    wait_clear(bc, dn, rdy);
    model_clear();
    n_checks += 3;
    if (bc != WDS)    begin n_fail++; $display("FAIL rst_reclear_cycles: got %0d want %0d", bc, WDS); end
    if (dn != 1)      begin n_fail++; $display("FAIL rst_reclear_done: got %0d want 1", dn); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL rst_reclear_ready: got %b want 1", rdy); end
    rd_pix(9, 9, v);
    n_checks++;
    if (v !== model_px(9, 9)) begin n_fail++; $display("FAIL rst_read_9_9: got %b want %b", v, model_px(9, 9)); end
    rd_pix(3, 3, v);
    n_checks++;
    if (v !== model_px(3, 3)) begin n_fail++; $display("FAIL rst_read_3_3: got %b want %b", v, model_px(3, 3)); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_write();
    test_collision();
    test_word_rmw();
    test_oob();
    test_back_to_back();
    test_clear_collision();
    test_clear_during_rmw();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
